des_key_schedule: RTL
=====================

# des_key_schedule

Sequential DES key-schedule generator that sits directly upstream of the DES encryption datapath. It expands a 64-bit key into the sixteen 48-bit round subkeys, one per cycle, and stores them in an internal register file. The encryption/decryption datapath then reads them in encryption or decryption order through a registered read port. Bit numbering follows DES convention throughout: bit 0 is the MSB (leftmost DES bit 1).

## Interface
- No parameters. The round count (16), PC-1, PC-2 and the shift schedule are fixed by FIPS 46-3.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new schedule; sampled only in IDLE.
- mode  in  1  1 = decryption order, 0 = encryption order; latched with start.
- key  in  [0:63]  DES key, parity bits at positions 7,15,…,63; latched with start.
- busy  out  1  generation in progress.
- done  out  1  one-cycle pulse on the cycle after the 16th subkey write.
- ready  out  1  level; the register file holds a complete valid schedule.
- subkey_valid  out  1  streaming strobe, one per generated subkey.
- subkey  out  [0:47]  streamed subkey K(n), always streamed in generation order K1..K16.
- subkey_round  out  4  n−1 for the streamed subkey (0..15).
- rd_addr  in  4  round index i, where 0 is the first round applied.
- rd_subkey  out  [0:47]  registered read data.
- parity_err  out  1  see Configuration.

## Operation
- FSM states are IDLE and GEN.
- **IDLE, start=1 (edge E0):**
  - Latch mode.
  - C ← PC-1 left half, D ← PC-1 right half (28 bits each).
  - Round counter r ← 0; ready ← 0; busy ← 1; go to GEN.
- **GEN, each edge:**
  - Rotate C and D left by s(r), where s = 1 for r ∈ {0,1,8,15} and 2 otherwise.
  - K(r+1) = PC-2 of the rotated {C,D}.
  - Write K(r+1) to regfile[r].
  - Drive subkey/subkey_round/subkey_valid from the same edge.
  - r ← r+1.
- **After the edge with r=15:** go to IDLE; busy ← 0; ready ← 1; done ← 1 for one cycle.
- **Read port:**
  - rd_subkey ← regfile[rd_addr] if latched mode=0, regfile[15−rd_addr] if mode=1.
  - rd_subkey is forced to 0 while ready=0.
- **Boundary conditions:**
  - start while busy: ignored. key and mode are not re-sampled.
  - start in IDLE with ready=1: ready drops at E0 and the whole schedule is regenerated; there are no partial updates.
  - mode changes outside a start: no effect.
  - rd_addr is always in range (4 bits, 16 entries). There is no wrap issue.

## Timing
- start sampled at E0; subkeys written at E1..E16.
- subkey_valid is high for exactly 16 consecutive cycles following E1..E16.
- done and ready both assert after E16; done coincides with the last subkey_valid cycle.
- Start-to-done latency is 16 cycles. Minimum start-to-start period is 17 cycles.
- Read latency is 1 cycle (rd_addr at edge N → rd_subkey valid after edge N).
- **Reset (any time, including mid-GEN):**
  - state=IDLE, r=0, C=D=0, mode=0.
  - The register file is cleared to 0.
  - busy, done, ready, subkey_valid, parity_err, subkey, subkey_round and rd_subkey are all 0.
  - No subkey_valid or done pulse follows a reset.

## Configuration
- **With DES_KS_PARITY_CHECK_EN defined:**
  - At E0 each key byte is checked for odd parity.
  - If any byte fails: parity_err ← 1, the FSM stays in IDLE, ready stays 0 and no subkeys are generated.
  - parity_err clears on the next accepted start or on rst.
- **Without the macro:**
  - parity_err is tied to 0.
  - Parity bits are ignored, as PC-1 discards them.

## Test plan
- **Reference vector:** rst, then start with key=0x133457799BBCDFF1, mode=0.
  - subkey_round 0 gives 0x1B02EFFC7072; round 1 gives 0x79AED9DBC9E5; round 15 gives 0xCB3D8B0E17F5.
  - done and ready rise exactly 16 cycles after start.
- **Decryption order:** same key, mode=1.
  - rd_addr=0 reads 0xCB3D8B0E17F5; rd_addr=15 reads 0x1B02EFFC7072, each one cycle after the address is applied.
- **Start while busy:** pulse start again at cycle 5 of GEN with a different key.
  - It is ignored; the full 0x1334… schedule completes with exactly 16 subkey_valid pulses.
- **Reset mid-operation:** assert rst at cycle 8 of GEN.
  - All outputs go to 0 immediately and there is no done pulse.
  - A new start afterwards produces the correct schedule.
- **Regeneration:** with ready=1, start with key=0.
  - ready falls the next cycle; all 16 rd_subkey reads return 0 after done.
- **Parity (macro on):** start with key=0x0000000000000000.
  - parity_err=1, busy stays 0, no subkey_valid.
  - A following start with key 0x133457799BBCDFF1 clears parity_err and completes normally.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into 16 round subkeys, one per cycle, into a regfile read in enc/dec order.
// Latency: 16 cycles start-to-done, 1-cycle registered read; optional DES_KS_PARITY_CHECK_EN rejects bad-parity keys.
// Backpressure: none; start is ignored while busy, so the minimum start-to-start period is 17 cycles.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [0:63] key,
  output logic        busy,
  output logic        done,
  output logic        ready,
  output logic        subkey_valid,
  output logic [0:47] subkey,
  output logic [3:0]  subkey_round,
  input  logic [3:0]  rd_addr,
  output logic [0:47] rd_subkey,
  output logic        parity_err
);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  // Tables hold 1-based DES bit numbers; index = value - 1 on the [0:N] vectors.
  localparam logic [5:0] PC1 [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };
  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    for (int i = 0; i < 56; i++) r[i] = k[PC1[i] - 6'd1];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    for (int i = 0; i < 48; i++) r[i] = cd[PC2[i] - 6'd1];
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [0:27] c, d, c_rot, d_rot;
  logic [3:0]  rnd;
  logic        mode_q;
  logic        key_ok, start_idle, accept, last, one_shift;
  logic [0:47] k_nxt;
  logic [3:0]  rd_idx;
  logic [0:47] regfile [16];

`ifdef DES_KS_PARITY_CHECK_EN
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) key_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (start_idle) parity_err <= !key_ok;
  end
`else
  logic unused_parity;
  assign key_ok        = 1'b1;
  assign parity_err    = 1'b0;
  assign unused_parity = ^{key[7], key[15], key[23], key[31], key[39], key[47], key[55], key[63]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && key_ok) state_nxt = GEN;
      GEN:  if (rnd == 4'd15)    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == GEN);
    start_idle = (state == IDLE) && start;
    accept     = start_idle && key_ok;
    last       = (state == GEN) && (rnd == 4'd15);
  end

  assign one_shift = (rnd == 4'd0) || (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15);
  assign c_rot     = one_shift ? {c[1:27], c[0]} : {c[2:27], c[0:1]};
  assign d_rot     = one_shift ? {d[1:27], d[0]} : {d[2:27], d[0:1]};
  assign k_nxt     = pc2({c_rot, d_rot});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c            <= '0;
      d            <= '0;
      rnd          <= '0;
      mode_q       <= 1'b0;
      ready        <= 1'b0;
      done         <= 1'b0;
      subkey_valid <= 1'b0;
      subkey       <= '0;
      subkey_round <= '0;
    end else begin
      done         <= last;
      subkey_valid <= busy;
      // Any start seen in IDLE invalidates the old schedule, even a rejected one.
      if (start_idle) ready <= 1'b0;
      else if (last)  ready <= 1'b1;
      if (accept) begin
        mode_q <= mode;
        {c, d} <= pc1(key);
        rnd    <= '0;
      end else if (busy) begin
        c            <= c_rot;
        d            <= d_rot;
        rnd          <= rnd + 4'd1;
        subkey       <= k_nxt;
        subkey_round <= rnd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regfile[i] <= '0;
    end else if (busy) begin
      regfile[rnd] <= k_nxt;
    end
  end

  // Decryption order reads entry 15 - rd_addr, which is the bitwise complement in 4 bits.
  assign rd_idx = mode_q ? ~rd_addr : rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rd_subkey <= '0;
    else if (!ready || start_idle) rd_subkey <= '0;
    else                          rd_subkey <= regfile[rd_idx];
  end

endmodule
